// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit_if
//  Brief    : Fetch-prediction and execute-resolve bundle of the branch
//             prediction unit. master = pipeline side, slave = predictor.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;

    logic            res_valid;
    logic            res_flush;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] res_rs1;
    logic [XLEN-1:0] res_rs2;
    logic [2:0]      res_funct3;
    logic [XLEN-1:0] res_imm;
    logic            res_pred_taken;

    logic            out_valid;
    logic            out_taken;
    logic            out_illegal;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;
    logic [31:0]     mispredict_count;

    modport master (
        output pred_pc, res_valid, res_flush, res_pc, res_rs1, res_rs2,
               res_funct3, res_imm, res_pred_taken,
        input  pred_taken, out_valid, out_taken, out_illegal, out_mispredict,
               out_redirect_pc, mispredict_count
    );

    modport slave (
        input  pred_pc, res_valid, res_flush, res_pc, res_rs1, res_rs2,
               res_funct3, res_imm, res_pred_taken,
        output pred_taken, out_valid, out_taken, out_illegal, out_mispredict,
               out_redirect_pc, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Brief    : Branch condition resolution, redirect/mispredict generation and
//             a PC-indexed BHT of 2-bit saturating counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_predict_unit #(
    parameter int          XLEN            = 32,
    parameter int          BHT_ENTRIES     = 64,
    parameter int          PIPE            = 1,
    // Value the mispredict counter takes on reset; 0 in normal use.
    parameter logic [31:0] CNT_RESET_VALUE = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);

    localparam int c_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]         r_bht [BHT_ENTRIES];
    logic [31:0]        r_count;

    logic [c_IDX_W-1:0] w_pred_idx;
    logic [c_IDX_W-1:0] w_res_idx;
    logic               w_taken;
    logic               w_illegal;
    logic               w_fire;
    logic               w_update;
    logic               w_mispredict;
    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_fallthrough;
    logic [XLEN-1:0]    w_redirect;
    logic               w_unused_ok;

    assign w_pred_idx    = bus.pred_pc[c_IDX_W+1:2];
    assign w_res_idx     = bus.res_pc[c_IDX_W+1:2];
    assign w_target      = bus.res_pc + bus.res_imm;
    assign w_fallthrough = bus.res_pc + XLEN'(4);
    assign w_redirect    = w_taken ? w_target : w_fallthrough;

    // Bits of the fetch PC that do not take part in the table index.
    assign w_unused_ok   = &{1'b0, bus.pred_pc[XLEN-1:c_IDX_W+2], bus.pred_pc[1:0]};

    // Prediction is the MSB of the indexed counter; no bypass of same-cycle writes.
    assign bus.pred_taken = r_bht[w_pred_idx][1];

    // Branch condition decode; reserved funct3 codes resolve as not taken.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (bus.res_funct3)
            3'b000:  w_taken = (bus.res_rs1 == bus.res_rs2);
            3'b001:  w_taken = (bus.res_rs1 != bus.res_rs2);
            3'b100:  w_taken = ($signed(bus.res_rs1) <  $signed(bus.res_rs2));
            3'b101:  w_taken = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
            3'b110:  w_taken = (bus.res_rs1 <  bus.res_rs2);
            3'b111:  w_taken = (bus.res_rs1 >= bus.res_rs2);
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_fire       = bus.res_valid & ~bus.res_flush;
    assign w_update     = w_fire & ~w_illegal;
    assign w_mispredict = ~w_illegal & (w_taken != bus.res_pred_taken);

    // BHT training: saturating increment on taken, decrement on not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_update) begin
            if (w_taken) begin
                if (r_bht[w_res_idx] != 2'b11) r_bht[w_res_idx] <= r_bht[w_res_idx] + 2'b01;
            end else begin
                if (r_bht[w_res_idx] != 2'b00) r_bht[w_res_idx] <= r_bht[w_res_idx] - 2'b01;
            end
        end
    end

    // Mispredict counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_RESET_VALUE;
        end else if (w_update && w_mispredict && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign bus.mispredict_count = r_count;

    generate
        if (PIPE == 0) begin : g_comb
            assign bus.out_valid       = w_fire;
            assign bus.out_taken       = w_taken;
            assign bus.out_illegal     = w_illegal;
            assign bus.out_mispredict  = w_mispredict;
            assign bus.out_redirect_pc = w_redirect;
        end else begin : g_pipe
            logic            r_out_valid;
            logic            r_out_taken;
            logic            r_out_illegal;
            logic            r_out_mispredict;
            logic [XLEN-1:0] r_out_redirect_pc;

            // Result register: flags clear when idle, redirect PC holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid       <= 1'b0;
                    r_out_taken       <= 1'b0;
                    r_out_illegal     <= 1'b0;
                    r_out_mispredict  <= 1'b0;
                    r_out_redirect_pc <= '0;
                end else begin
                    r_out_valid      <= w_fire;
                    r_out_taken      <= w_fire & w_taken;
                    r_out_illegal    <= w_fire & w_illegal;
                    r_out_mispredict <= w_fire & w_mispredict;
                    if (w_fire) r_out_redirect_pc <= w_redirect;
                end
            end

            assign bus.out_valid       = r_out_valid;
            assign bus.out_taken       = r_out_taken;
            assign bus.out_illegal     = r_out_illegal;
            assign bus.out_mispredict  = r_out_mispredict;
            assign bus.out_redirect_pc = r_out_redirect_pc;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_unit
//  Brief    : Scoreboard bench: registered instance (main tests) plus a
//             combinational instance with the counter preset near saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int c_XLEN = 32;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        mispredict;
        logic [31:0] redirect;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    exp_t r_sb[$];
    logic [1:0]  m_bht [64];
    logic [31:0] m_count;

    branch_predict_unit_if #(.XLEN(c_XLEN)) bus0 ();
    branch_predict_unit_if #(.XLEN(c_XLEN)) bus1 ();

    branch_predict_unit #(.XLEN(c_XLEN), .BHT_ENTRIES(64), .PIPE(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    branch_predict_unit #(.XLEN(c_XLEN), .BHT_ENTRIES(64), .PIPE(0),
                          .CNT_RESET_VALUE(32'hFFFF_FFFD)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] diff;
        logic        slt;
        diff = {1'b0, a} - {1'b0, b};
        slt  = (a[31] != b[31]) ? a[31] : diff[31];
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return slt;
            3'b101:  return !slt;
            3'b110:  return diff[32];
            3'b111:  return !diff[32];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset(input logic [31:0] cnt);
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_count = cnt;
    endtask

    // Scoreboard consumer for the registered instance.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid) begin
            check("sb_has_entry", 64'(r_sb.size() > 0), 64'd1);
            if (r_sb.size() > 0) begin
                exp_t e;
                e = r_sb.pop_front();
                check("out_taken",      64'(bus0.out_taken),       64'(e.taken));
                check("out_illegal",    64'(bus0.out_illegal),     64'(e.illegal));
                check("out_mispredict", 64'(bus0.out_mispredict),  64'(e.mispredict));
                check("out_redirect",   64'(bus0.out_redirect_pc), 64'(e.redirect));
            end
        end
    end

    // Drive one resolve for one cycle on the registered instance; caller is just past a posedge.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm, input logic pred,
                           input logic flush, input logic expect_out);
        exp_t e;
        logic tk;
        logic ill;
        logic [5:0] idx;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        tk  = ref_taken(f3, rs1, rs2);
        idx = pc[7:2];
        e.taken      = tk;
        e.illegal    = ill;
        e.mispredict = !ill && (tk != pred);
        e.redirect   = tk ? pc + imm : pc + 32'd4;
        bus0.res_valid      = 1'b1;
        bus0.res_flush      = flush;
        bus0.res_pc         = pc;
        bus0.res_rs1        = rs1;
        bus0.res_rs2        = rs2;
        bus0.res_funct3     = f3;
        bus0.res_imm        = imm;
        bus0.res_pred_taken = pred;
        if (!flush && expect_out) r_sb.push_back(e);
        @(posedge clk);
        #1;
        bus0.res_valid = 1'b0;
        bus0.res_flush = 1'b0;
        if (!flush && !ill) begin
            if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
            if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
            if (e.mispredict && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
        check("count", 64'(bus0.mispredict_count), 64'(m_count));
    endtask

    task automatic check_pred(input logic [31:0] pc, input string tag);
        logic [5:0] idx;
        idx = pc[7:2];
        bus0.pred_pc = pc;
        #1;
        check(tag, 64'(bus0.pred_taken), 64'(m_bht[idx][1]));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus0.pred_pc = '0; bus0.res_valid = 1'b0; bus0.res_flush = 1'b0;
        bus0.res_pc = '0; bus0.res_rs1 = '0; bus0.res_rs2 = '0;
        bus0.res_funct3 = '0; bus0.res_imm = '0; bus0.res_pred_taken = 1'b0;
        bus1.pred_pc = '0; bus1.res_valid = 1'b0; bus1.res_flush = 1'b0;
        bus1.res_pc = '0; bus1.res_rs1 = '0; bus1.res_rs2 = '0;
        bus1.res_funct3 = '0; bus1.res_imm = '0; bus1.res_pred_taken = 1'b0;
        model_reset(32'd0);
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        check("rst_out_valid",    64'(bus0.out_valid),        64'd0);
        check("rst_out_taken",    64'(bus0.out_taken),        64'd0);
        check("rst_out_illegal",  64'(bus0.out_illegal),      64'd0);
        check("rst_out_mispred",  64'(bus0.out_mispredict),   64'd0);
        check("rst_out_redirect", 64'(bus0.out_redirect_pc),  64'd0);
        check("rst_count",        64'(bus0.mispredict_count), 64'd0);
        check_pred(32'h100, "pred_0x100");
        for (int i = 0; i < 64; i++) check_pred(32'(i * 4), "pred_rst_sweep");

        // Backward taken branch mispredicted as not taken
        resolve(32'h40, 32'd5, 32'd5, 3'b000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
        check("count_first", 64'(bus0.mispredict_count), 64'd1);
        check_pred(32'h40, "pred_after_train");
        check("pred_now_taken", 64'(bus0.pred_taken), 64'd1);

        // funct3 sweep
        resolve(32'h200, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'h10, 1'b0, 1'b0, 1'b1);
        resolve(32'h204, 32'hFFFF_FFFF, 32'd1, 3'b110, 32'h10, 1'b0, 1'b0, 1'b1);
        resolve(32'h208, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'h10, 1'b1, 1'b0, 1'b1);
        resolve(32'h20C, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'h10, 1'b1, 1'b0, 1'b1);
        resolve(32'h210, 32'd5, 32'd5, 3'b000, 32'h20, 1'b1, 1'b0, 1'b1);
        resolve(32'h214, 32'd5, 32'd5, 3'b001, 32'h20, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Saturation: four taken then one not taken at the same pc
        for (int k = 0; k < 4; k++) begin
            resolve(32'h80, 32'd1, 32'd2, 3'b110, 32'h100, m_bht[6'h20][1], 1'b0, 1'b1);
        end
        check("bht_sat_st", 64'(m_bht[6'h20]), 64'd3);
        resolve(32'h80, 32'd3, 32'd2, 3'b110, 32'h100, 1'b1, 1'b0, 1'b1);
        check_pred(32'h80, "pred_after_wt");

        // Flush: no output, no training, no count
        resolve(32'h300, 32'd1, 32'd2, 3'b001, 32'h8, 1'b0, 1'b1, 1'b1);
        check_pred(32'h300, "pred_after_flush");
        // Reserved funct3
        resolve(32'h304, 32'd1, 32'd2, 3'b010, 32'h8, 1'b1, 1'b0, 1'b1);
        check_pred(32'h304, "pred_after_illegal");
        // PC wrap on fallthrough
        resolve(32'hFFFF_FFFC, 32'd7, 32'd7, 3'b001, 32'h40, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("sb_drained", 64'(r_sb.size()), 64'd0);

        // Reset while a registered result is on the outputs
        resolve(32'h40, 32'd1, 32'd1, 3'b000, 32'h8, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", 64'(bus0.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus0.out_valid),        64'd0);
        check("async_rst_count", 64'(bus0.mispredict_count), 64'd0);
        model_reset(32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        check_pred(32'h40, "pred_post_rst_0x40");
        check_pred(32'h80, "pred_post_rst_0x80");

        // Combinational instance: same-cycle results and count saturation
        m_count = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) begin
            bus1.res_valid = 1'b1; bus1.res_flush = 1'b0;
            bus1.res_pc = 32'h1000; bus1.res_rs1 = 32'd9; bus1.res_rs2 = 32'd3;
            bus1.res_funct3 = 3'b101; bus1.res_imm = 32'h80; bus1.res_pred_taken = 1'b0;
            #1;
            check("c_out_valid",    64'(bus1.out_valid),       64'd1);
            check("c_out_taken",    64'(bus1.out_taken),       64'd1);
            check("c_out_mispred",  64'(bus1.out_mispredict),  64'd1);
            check("c_out_redirect", 64'(bus1.out_redirect_pc), 64'h1080);
            @(posedge clk);
            #1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            check("c_count", 64'(bus1.mispredict_count), 64'(m_count));
        end
        bus1.res_flush = 1'b1;
        #1;
        check("c_flush_valid", 64'(bus1.out_valid), 64'd0);
        bus1.res_valid = 1'b0;
        bus1.res_flush = 1'b0;
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
